sop_eval_pipe: RTL

Parametrised, programmable sum-of-products evaluator. It generalises the fixed Y=AB+CD+E function to N_IN inputs and N_TERMS run-time-configurable product terms. The output is registered and carries a valid/ready handshake. A built-in sweep engine walks all 2^N_IN input vectors and returns the truth-table ones-count, for self-check against the golden function in the bench.

---
 rtl/sop_eval_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sop_eval_pipe.sv
// Purpose: programmable sum-of-products evaluator with an exhaustive truth-table sweep engine.
// Latency: one cycle from accepted vector to registered y; a sweep takes 2^N_IN RUN cycles plus one DONE cycle.
// Backpressure: in_ready drops while a sweep runs; results are never stalled, so there is no output ready.
module sop_eval_pipe #(
    parameter int N_IN    = 5,
    parameter int N_TERMS = 3,
    parameter int IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
    parameter int CNT_W   = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_pol,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic             y,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Per-term configuration: care selects participating inputs, pol their required value.
    logic [N_IN-1:0]   care_q [N_TERMS];
    logic [N_IN-1:0]   pol_q  [N_TERMS];

    // Sweep walker: v_q is the vector under test, acc_q the running ones-count.
    logic [N_IN-1:0]   v_q;
    logic [CNT_W-1:0]  acc_q;

    logic              f_in;
    logic              f_sw;
    logic              accept;

    assign in_ready   = (state_q != S_RUN);
    assign sweep_busy = (state_q == S_RUN);
    assign sweep_done = (state_q == S_DONE);
    assign accept     = in_valid & in_ready;

    // Evaluate the SOP for both the external vector and the sweep vector; a term with no cared inputs is off.
    always_comb begin
        f_in = 1'b0;
        f_sw = 1'b0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (|care_q[t]) begin
                if (((in_vec ^ pol_q[t]) & care_q[t]) == '0) begin
                    f_in = 1'b1;
                end
                if (((v_q ^ pol_q[t]) & care_q[t]) == '0) begin
                    f_sw = 1'b1;
                end
            end
        end
    end

    // Sweep FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep FSM next-state: start only from IDLE, finish after the all-ones vector, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (v_q == '1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Configuration writes; frozen during a sweep so the count reflects one consistent function.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TERMS; t++) begin
                care_q[t] <= '0;
                pol_q[t]  <= '0;
            end
        end else if (cfg_we && (state_q != S_RUN)) begin
            // Indices at or beyond N_TERMS match no slot and are dropped.
            for (int t = 0; t < N_TERMS; t++) begin
                if (cfg_idx == IDX_W'(t)) begin
                    care_q[t] <= cfg_care;
                    pol_q[t]  <= cfg_pol;
                end
            end
        end
    end

    // Evaluation pipeline: one registered result per accepted vector, y held between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                y <= f_in;
            end
        end
    end

    // Sweep datapath: clear on start, accumulate per RUN cycle, publish the total on the last vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            acc_q       <= '0;
            sweep_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sweep_start) begin
                        v_q   <= '0;
                        acc_q <= '0;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_q + CNT_W'(f_sw);
                    v_q   <= v_q + 1'b1;
                    if (v_q == '1) begin
                        sweep_count <= acc_q + CNT_W'(f_sw);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
